// File: rtl/spi_master.sv
// SPI mode-0 master: serialises bytes from a valid/ready stream MSB-first on
// MOSI and reassembles MISO into bytes.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   tx_data/tx_last   byte to send and end-of-frame marker, taken on accept
//   tx_valid/tx_ready transmit handshake; accept when both are high
//   rx_data/rx_valid  received byte with a one-cycle valid pulse
//   busy              high from accept until the inter-frame gap completes
//   SCK/MOSI/SSEL     SPI pins driven to the slave (SCK idles low, SSEL low-active)
//   MISO              asynchronous serial data from the slave
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  output logic       SSEL,
  input  logic       MISO
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD)
                                  ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                  : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;   // position inside the current SCK half-period
  logic [CNT_W-1:0] cnt;       // shared setup/hold/gap counter
  logic [2:0]       bit_cnt;   // index of the bit on the wire, 7 down to 0
  logic [7:0]       tx_byte;
  logic             tx_last_q;
  logic [7:0]       rx_shift;
  logic             lead;      // low lead-in phase before the first rise of a resumed byte
  logic             miso_meta;
  logic             miso_s;

  // Two-flop synchroniser for the asynchronous MISO pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_s    <= miso_meta;
    end
  end

  // Frame sequencer with registered pin and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      cnt       <= '0;
      bit_cnt   <= 3'd7;
      tx_byte   <= 8'h00;
      tx_last_q <= 1'b0;
      rx_shift  <= 8'h00;
      lead      <= 1'b0;
      tx_ready  <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      SSEL      <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          SSEL <= 1'b1;
          SCK  <= 1'b0;
          busy <= 1'b0;
          if (tx_valid && tx_ready) begin
            tx_byte   <= tx_data;
            tx_last_q <= tx_last;
            MOSI      <= tx_data[7];
            SSEL      <= 1'b0;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
            cnt       <= '0;
            state     <= SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            SCK     <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= 3'd7;
            lead    <= 1'b0;
            state   <= XFER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        XFER: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (SCK) begin
              // End of high phase: sample MISO, fall SCK, present next bit
              SCK      <= 1'b0;
              rx_shift <= {rx_shift[6:0], miso_s};
              if (bit_cnt != 3'd0) begin
                MOSI <= tx_byte[bit_cnt - 3'd1];
              end
            end else if (lead) begin
              lead <= 1'b0;
              SCK  <= 1'b1;
            end else if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              SCK     <= 1'b1;
            end else begin
              // End of the eighth low phase: byte complete
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              cnt      <= '0;
              if (tx_last_q) begin
                state <= HOLD;
              end else begin
                tx_ready <= 1'b1;
                state    <= WAIT;
              end
            end
          end
        end

        WAIT: begin
          SCK <= 1'b0;
          if (tx_valid && tx_ready) begin
            tx_byte   <= tx_data;
            tx_last_q <= tx_last;
            MOSI      <= tx_data[7];
            tx_ready  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= 3'd7;
            lead      <= 1'b1;
            state     <= XFER;
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            SSEL  <= 1'b1;
            MOSI  <= 1'b0;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 master that drives the SCK/MOSI/SSEL pins of the SPI slave on the board and collects the slave's MISO response. It serialises bytes from a valid/ready transmit stream MSB-first. It reassembles received bytes into a one-cycle-pulse receive stream. It is used as the test/host-side initiator and for on-chip links to slave peripherals.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period; legal range >= 4, because the slave syncs SCK through 3 flops.
CS_SETUP, 2, clk cycles from SSEL falling to the first SCK rising edge; legal range >= 1.
CS_HOLD, 2, clk cycles from the last SCK falling edge to SSEL rising; legal range >= 1.
CS_GAP, 4, minimum clk cycles SSEL stays high between frames; legal range >= 2.

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst  in  1  asynchronous reset, active-high
tx_data  in  8  byte to send
tx_last  in  1  marks the final byte of a frame; sampled with tx_data
tx_valid  in  1  tx_data/tx_last are valid
tx_ready  out  1  master accepts a byte this cycle
rx_data  out  8  byte received on MISO
rx_valid  out  1  one-cycle pulse; rx_data is new
busy  out  1  high from byte accept until the end of the CS_GAP period
SCK  out  1  SPI clock, idles low
MOSI  out  1  serial data to the slave
SSEL  out  1  slave select, active-low
MISO  in  1  serial data from the slave; asynchronous

Behaviour:
- Reset (asynchronous) values: SSEL=1, SCK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, state=IDLE.
- tx_ready is asserted from the first clk after rst deasserts.
- All outputs are registered.
- MISO passes through a 2-flop synchroniser before it is used.
- States: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- Handshake: a byte transfers on a cycle with tx_valid & tx_ready.
  - tx_ready=1 only in IDLE and WAIT.
  - tx_data and tx_last are captured on the accept cycle.
- IDLE:
  - Hold SSEL=1, SCK=0, busy=0.
  - On accept: next cycle SSEL=0, MOSI=tx_data[7], busy=1, go to SETUP.
- SETUP: count CS_SETUP cycles, then go to XFER.
- XFER: 8 bits, MSB first. Per bit:
  - SCK high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - The synchronised MISO is sampled on the last cycle of each high phase, which is the same cycle SCK is driven low.
  - MOSI changes to the next bit on the cycle SCK goes low, for bits 6..0 only.
- End of byte, at the end of the 8th low phase:
  - rx_data is updated and rx_valid pulses for exactly 1 cycle.
  - If the captured tx_last=1, go to HOLD. Otherwise go to WAIT.
- WAIT:
  - SSEL stays 0, SCK stays 0, tx_ready=1.
  - Stays indefinitely until accept.
  - On accept: MOSI=new bit7 next cycle, then CLK_DIV low cycles, then XFER resumes with SCK rising.
- HOLD: hold SSEL=0 and SCK=0 for CS_HOLD cycles, then drive SSEL=1 and go to GAP.
- GAP:
  - SSEL=1 for CS_GAP cycles, then IDLE.
  - busy drops on the cycle IDLE is entered.
  - tx_ready is 0 throughout GAP.
- Bit timing: exactly 8 SCK rising edges per byte. SCK is never high outside XFER.
- Counters must wrap cleanly:
  - half-period counter: 0..CLK_DIV-1
  - bit counter: 7..0, reloads on each byte
  - setup/hold/gap counters
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values.
  - SSEL rises without completing the byte.
  - No rx_valid is produced for the partial byte.
- tx_valid while busy and not in WAIT is ignored; no accept occurs.
- rx_data holds its value until the next rx_valid.

Test Plan:
- Single byte, MISO tied to MOSI (loopback), tx_data=0xA5 with tx_last=1 -> SSEL low for CS_SETUP+16*CLK_DIV+CS_HOLD = 68 cycles; 8 SCK pulses; rx_valid one pulse with rx_data=0xA5; busy drops after the 4-cycle gap.
- Master connected to the SPI slave model (slave always answers 0x04 on the byte after a received byte), sending 0x01 then 0x00 (last) -> second rx_data=0x04, first rx_data=0x00.
- Back-to-back frame: tx_valid held with 0x3C(last) then 0xC3(last) -> SSEL high for >=4 cycles between frames; tx_ready low during GAP.
- WAIT stall: send 0x11 (not last), delay tx_valid for 20 cycles -> SSEL stays 0, SCK stays 0, tx_ready=1; then 0x22(last) completes; loopback rx gives 0x11 then 0x22.
- Async reset asserted during bit 3 -> SSEL=1, SCK=0, MOSI=0 with no clk edge needed; no rx_valid; next 0x5A frame after release completes correctly.
- MOSI/SCK phase check with CLK_DIV=6: MOSI stable for >=6 cycles around every SCK rising edge; MOSI changes only on SCK-fall cycles.
